biasgen_seq: RTL and testbench

- Multi-channel successor to the single-channel bias generator; produces NCH pwl bias currents for opamps and comparators.
- Adds clocked power-up sequencing: a global wakeup wait, then staggered per-channel turn-on to limit inrush.
- Adds a per-channel signed trim code and ready flags.
- Sits between the power/control block and the analog cores that consume the bias currents.

---
 rtl/biasgen_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_biasgen_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biasgen_seq.sv
// Multi-channel bias generator with staggered power-up sequencing and per-channel signed trim.
// Optional per-channel soft-start staircase when BIASGEN_SEQ_SOFTSTART_EN is defined.
`timescale 1ns/1ps

package biasgen_seq_pkg;
    // Piecewise-linear sample: value a, slope b, anchor time t (ps).
    // avdd: a in uV, b in uV/us. vbn: a in zA (1e-21 A), b in 1e-21 A/us.
    typedef struct packed {
        logic signed [63:0] a;
        logic signed [63:0] b;
        logic        [63:0] t;
    } pwl_t;
endpackage

module biasgen_seq #(
    parameter int  NCH         = 4,
    parameter int  TRIM_W      = 4,
    parameter real TRIM_LSB    = 0.01,
    parameter real I0          = -58.88e-6,
    parameter real I1          = 46.91e-6,
    parameter int  WAKE_CYC    = 8,
    parameter int  STAGGER_CYC = 2
) (
    input  logic                           clk,
    input  logic                           rstb,
    input  biasgen_seq_pkg::pwl_t          avdd,
    input  biasgen_seq_pkg::pwl_t          avss,
    input  logic                           pwdn,
    input  logic [NCH-1:0]                 ch_en,
    input  logic [NCH*TRIM_W-1:0]          trim,
    output biasgen_seq_pkg::pwl_t [NCH-1:0] vbn,
    output logic [NCH-1:0]                 ch_rdy,
    output logic                           all_rdy,
    output logic                           busy
);

    localparam int W_EFF = (WAKE_CYC < 1) ? 1 : WAKE_CYC;
    localparam int S_EFF = (STAGGER_CYC < 1) ? 1 : STAGGER_CYC;
    localparam int MAXC  = (W_EFF > S_EFF) ? W_EFF : S_EFF;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(W_EFF - 1);
    localparam logic [CNT_W-1:0] STAG_LOAD = CNT_W'(S_EFF - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NCH - 1);

    // Integer model coefficients: fA offset, fA per uV, gain step in ppm.
    localparam longint I0_FA        = longint'(I0 * 1.0e15);
    localparam longint I1_FA_UV     = longint'(I1 * 1.0e9);
    localparam longint TRIM_LSB_PPM = longint'(TRIM_LSB * 1.0e6);
    localparam longint UNITY_PPM    = 64'sd1000000;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAIT = 2'd1,
        ST_STEP = 2'd2,
        ST_ON   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NCH-1:0]        on_q, on_d;
    logic [NCH-1:0]        act_d;
    logic [NCH-1:0]        ch_rdy_q, ch_rdy_d;
    logic                  all_rdy_q, all_rdy_d;
    logic [NCH*TRIM_W-1:0] trim_q, trim_d;
    logic [NCH-1:0]        gate;

`ifdef BIASGEN_SEQ_SOFTSTART_EN
    logic [NCH-1:0]        act_q;
    logic [NCH-1:0][1:0]   r_q, r_d;
`endif

    logic signed [TRIM_W-1:0] tcode;
    longint                   gain_ppm;
    longint                   base_a;
    longint                   base_b;
    longint                   val_a;
    longint                   val_b;
    longint                   ramp;

    logic unused_avss;
    assign unused_avss = ^avss;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            idx_q     <= '0;
            on_q      <= '0;
            ch_rdy_q  <= '0;
            all_rdy_q <= 1'b0;
            trim_q    <= '0;
`ifdef BIASGEN_SEQ_SOFTSTART_EN
            act_q     <= '0;
            r_q       <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            on_q      <= on_d;
            ch_rdy_q  <= ch_rdy_d;
            all_rdy_q <= all_rdy_d;
            trim_q    <= trim_d;
`ifdef BIASGEN_SEQ_SOFTSTART_EN
            act_q     <= act_d;
            r_q       <= r_d;
`endif
        end
    end

    // WAIT exits on the edge that is WAKE_CYC edges after pwdn is first seen low,
    // so channel k turns on WAKE_CYC + (k+1)*STAGGER_CYC edges after that edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        on_d    = on_q;
        trim_d  = trim;
        if (pwdn) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            idx_d   = '0;
            on_d    = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    idx_d = '0;
                    if (W_EFF == 1) begin
                        state_d = ST_STEP;
                        cnt_d   = STAG_LOAD;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAKE_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_STEP;
                        idx_d   = '0;
                        cnt_d   = STAG_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_STEP: begin
                    if (cnt_q == '0) begin
                        on_d[idx_q] = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_ON;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            cnt_d = STAG_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_ON: begin
                    state_d = ST_ON;
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end

        act_d = on_d & ch_en;
`ifdef BIASGEN_SEQ_SOFTSTART_EN
        r_d      = '0;
        ch_rdy_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (act_d[i] && act_q[i]) begin
                r_d[i] = (r_q[i] == 2'd3) ? 2'd3 : r_q[i] + 2'd1;
            end
            ch_rdy_d[i] = act_d[i] & (r_d[i] == 2'd3);
        end
`else
        ch_rdy_d = act_d;
`endif
        all_rdy_d = (state_d == ST_ON) && (ch_rdy_d == ch_en);
    end

`ifdef BIASGEN_SEQ_SOFTSTART_EN
    assign gate = act_q;
`else
    assign gate = ch_rdy_q;
`endif

    // Output path is combinational so avdd segment changes propagate without a clock.
    always_comb begin
        vbn      = '0;
        tcode    = '0;
        gain_ppm = UNITY_PPM;
        val_a    = '0;
        val_b    = '0;
        ramp     = 64'sd4;
        base_a   = I0_FA + I1_FA_UV * avdd.a;
        base_b   = I1_FA_UV * avdd.b;
        for (int i = 0; i < NCH; i++) begin
            if (gate[i]) begin
                tcode    = trim_q[i*TRIM_W +: TRIM_W];
                gain_ppm = UNITY_PPM + TRIM_LSB_PPM * longint'(tcode);
                val_a    = base_a * gain_ppm;
                val_b    = base_b * gain_ppm;
`ifdef BIASGEN_SEQ_SOFTSTART_EN
                ramp     = longint'(r_q[i]) + 64'sd1;
                val_a    = (val_a * ramp) >>> 2;
                val_b    = (val_b * ramp) >>> 2;
`endif
                vbn[i].a = val_a;
                vbn[i].b = val_b;
                vbn[i].t = avdd.t;
            end
        end
    end

    assign ch_rdy  = ch_rdy_q;
    assign all_rdy = all_rdy_q;
    assign busy    = (state_q == ST_WAIT) || (state_q == ST_STEP);

endmodule

// File: tb/tb_biasgen_seq.sv
// Scoreboard bench for biasgen_seq: a timing/current reference model feeds a queue,
// and an independent monitor compares DUT outputs at each negedge or asynchronous avdd event.
`timescale 1ns/1ps

module tb_biasgen_seq;
    import biasgen_seq_pkg::*;

    localparam int  NCH         = 4;
    localparam int  TRIM_W      = 4;
    localparam int  WAKE_CYC    = 8;
    localparam int  STAGGER_CYC = 2;
    localparam real I0_A        = -58.88e-6;
    localparam real I1_A        = 46.91e-6;
    localparam real TRIM_STEP   = 0.01;

    logic                  clk = 1'b0;
    logic                  rstb = 1'b0;
    logic                  pwdn = 1'b1;
    logic [NCH-1:0]        ch_en = '0;
    logic [NCH*TRIM_W-1:0] trim = '0;
    pwl_t                  avdd = '0;
    pwl_t                  avss = '0;
    pwl_t [NCH-1:0]        vbn;
    logic [NCH-1:0]        ch_rdy;
    logic                  all_rdy;
    logic                  busy;

    biasgen_seq #(
        .NCH(NCH), .TRIM_W(TRIM_W), .TRIM_LSB(TRIM_STEP), .I0(I0_A), .I1(I1_A),
        .WAKE_CYC(WAKE_CYC), .STAGGER_CYC(STAGGER_CYC)
    ) dut (
        .clk(clk), .rstb(rstb), .avdd(avdd), .avss(avss), .pwdn(pwdn),
        .ch_en(ch_en), .trim(trim), .vbn(vbn), .ch_rdy(ch_rdy),
        .all_rdy(all_rdy), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          tag;
        logic [NCH-1:0] rdy;
        logic           all;
        logic           bsy;
        real            va [NCH];
        real            vb [NCH];
        longint         vt [NCH];
    } exp_t;

    exp_t sb [$];
    event chk_ev;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: readiness from the closed-form turn-on schedule.
    bit                    seq_active = 1'b0;
    longint                elapsed    = 0;
    logic [NCH*TRIM_W-1:0] trim_m     = '0;
    logic [NCH-1:0]        act_m      = '0;
    logic [NCH-1:0]        rdy_m      = '0;
    logic                  all_m      = 1'b0;
    logic                  busy_m     = 1'b0;
    int                    run_m [NCH];
    string                 phase      = "reset";

    function automatic int turn_on_edge(int k);
        int w;
        w = (WAKE_CYC < 1) ? 1 : WAKE_CYC;
        return w + (k + 1) * STAGGER_CYC;
    endfunction

    task automatic model_edge();
        bit on_state;
        if (!rstb) begin
            seq_active = 1'b0;
            elapsed    = 0;
            trim_m     = '0;
            act_m      = '0;
            rdy_m      = '0;
            all_m      = 1'b0;
            busy_m     = 1'b0;
            for (int k = 0; k < NCH; k++) run_m[k] = 0;
        end else begin
            trim_m = trim;
            if (pwdn) begin
                seq_active = 1'b0;
                elapsed    = 0;
            end else begin
                seq_active = 1'b1;
                elapsed    = elapsed + 1;
            end
            on_state = seq_active && (elapsed >= turn_on_edge(NCH - 1));
            for (int k = 0; k < NCH; k++) begin
                act_m[k] = seq_active && (elapsed >= turn_on_edge(k)) && ch_en[k];
                run_m[k] = act_m[k] ? ((run_m[k] >= 4) ? 4 : run_m[k] + 1) : 0;
`ifdef BIASGEN_SEQ_SOFTSTART_EN
                rdy_m[k] = (run_m[k] >= 4);
`else
                rdy_m[k] = act_m[k];
`endif
            end
            all_m  = on_state && (rdy_m == ch_en);
            busy_m = seq_active && !on_state;
        end
    endtask

    function automatic exp_t make_expect(string tag);
        exp_t                     e;
        logic signed [TRIM_W-1:0] c;
        longint                   av;
        longint                   ab;
        real                      g;
        real                      scale;
        e.tag = tag;
        e.rdy = rdy_m;
        e.all = all_m;
        e.bsy = busy_m;
        av = avdd.a;
        ab = avdd.b;
        for (int k = 0; k < NCH; k++) begin
            c = trim_m[k*TRIM_W +: TRIM_W];
            g = 1.0 + TRIM_STEP * real'(int'(c));
`ifdef BIASGEN_SEQ_SOFTSTART_EN
            scale = real'((run_m[k] >= 4) ? 4 : run_m[k]) / 4.0;
`else
            scale = 1.0;
`endif
            if (act_m[k]) begin
                e.va[k] = g * (I0_A + I1_A * real'(av) * 1.0e-6) * scale;
                e.vb[k] = g * I1_A * real'(ab) * scale;
                e.vt[k] = longint'(avdd.t);
            end else begin
                e.va[k] = 0.0;
                e.vb[k] = 0.0;
                e.vt[k] = 0;
            end
        end
        return e;
    endfunction

    task automatic check_output(input exp_t e);
        longint la, lb, lt;
        real    da, db;
        checks++;
        if (ch_rdy !== e.rdy) begin
            failures++;
            $display("[TB] FAIL %s ch_rdy got=%b exp=%b at %0t", e.tag, ch_rdy, e.rdy, $time);
        end
        checks++;
        if (all_rdy !== e.all) begin
            failures++;
            $display("[TB] FAIL %s all_rdy got=%b exp=%b at %0t", e.tag, all_rdy, e.all, $time);
        end
        checks++;
        if (busy !== e.bsy) begin
            failures++;
            $display("[TB] FAIL %s busy got=%b exp=%b at %0t", e.tag, busy, e.bsy, $time);
        end
        for (int k = 0; k < NCH; k++) begin
            la = vbn[k].a;
            lb = vbn[k].b;
            lt = vbn[k].t;
            da = real'(la) * 1.0e-21;
            db = real'(lb) * 1.0e-15;
            checks++;
            if ($isunknown(vbn[k]) || (da - e.va[k] > 1.0e-15 + 1.0e-9 * (e.va[k] < 0 ? -e.va[k] : e.va[k])) ||
                (e.va[k] - da > 1.0e-15 + 1.0e-9 * (e.va[k] < 0 ? -e.va[k] : e.va[k]))) begin
                failures++;
                $display("[TB] FAIL %s vbn[%0d].a got=%g exp=%g at %0t", e.tag, k, da, e.va[k], $time);
            end
            checks++;
            if ((db - e.vb[k] > 1.0e-9 + 1.0e-9 * (e.vb[k] < 0 ? -e.vb[k] : e.vb[k])) ||
                (e.vb[k] - db > 1.0e-9 + 1.0e-9 * (e.vb[k] < 0 ? -e.vb[k] : e.vb[k]))) begin
                failures++;
                $display("[TB] FAIL %s vbn[%0d].b got=%g exp=%g at %0t", e.tag, k, db, e.vb[k], $time);
            end
            checks++;
            if (lt != e.vt[k]) begin
                failures++;
                $display("[TB] FAIL %s vbn[%0d].t got=%0d exp=%0d at %0t", e.tag, k, lt, e.vt[k], $time);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk or chk_ev);
            while (sb.size() > 0) check_output(sb.pop_front());
        end
    end

    task automatic apply_stimulus(input logic r, input logic p, input logic [NCH-1:0] en,
                                  input logic [NCH*TRIM_W-1:0] tr, input longint a_uv, input longint b_uvus);
        rstb   = r;
        pwdn   = p;
        ch_en  = en;
        trim   = tr;
        avdd.a = a_uv;
        avdd.b = b_uvus;
        avdd.t = 64'($time);
    endtask

    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            sb.push_back(make_expect(phase));
            @(negedge clk);
            #1;
        end
    endtask

    task automatic async_check();
        #1;
        sb.push_back(make_expect({phase, "_async"}));
        -> chk_ev;
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        longint a_uv, b_uv;
        for (int k = 0; k < NCH; k++) run_m[k] = 0;

        phase = "reset";
        apply_stimulus(1'b0, 1'b0, 4'hF, '0, 64'sd1800000, 64'sd0);
        step_cycles(2);

        phase = "sequence";
        apply_stimulus(1'b1, 1'b0, 4'hF, '0, 64'sd1800000, 64'sd0);
        step_cycles(20);

        phase = "trim";
        apply_stimulus(1'b1, 1'b0, 4'hF, 16'h0040, 64'sd1800000, 64'sd0);
        step_cycles(2);
        apply_stimulus(1'b1, 1'b0, 4'hF, 16'h0840, 64'sd1800000, 64'sd0);
        step_cycles(2);

        phase = "ramp";
        apply_stimulus(1'b1, 1'b0, 4'hF, 16'h0840, 64'sd1800000, 64'sd1000000);
        async_check();
        step_cycles(2);

        phase = "abort";
        apply_stimulus(1'b1, 1'b1, 4'hF, '0, 64'sd1800000, 64'sd0);
        step_cycles(1);
        apply_stimulus(1'b1, 1'b0, 4'hF, '0, 64'sd1800000, 64'sd0);
        step_cycles(13);
        apply_stimulus(1'b1, 1'b1, 4'hF, '0, 64'sd1800000, 64'sd0);
        step_cycles(1);
        apply_stimulus(1'b1, 1'b0, 4'hF, '0, 64'sd1800000, 64'sd0);
        step_cycles(20);

        phase = "mask";
        apply_stimulus(1'b1, 1'b1, 4'b0101, '0, 64'sd1800000, 64'sd0);
        step_cycles(1);
        apply_stimulus(1'b1, 1'b0, 4'b0101, '0, 64'sd1800000, 64'sd0);
        step_cycles(18);
        apply_stimulus(1'b1, 1'b0, 4'b0111, '0, 64'sd1800000, 64'sd0);
        step_cycles(3);

        phase = "random";
        for (int n = 0; n < 1500; n++) begin
            a_uv = avdd.a;
            b_uv = avdd.b;
            if ($urandom_range(0, 9) == 0) begin
                a_uv = longint'($urandom_range(1000000, 2000000));
                b_uv = longint'($urandom_range(0, 4000000)) - 64'sd2000000;
            end
            apply_stimulus(
                ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1,
                pwdn ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 11) == 0) ? NCH'($urandom) : ch_en,
                ($urandom_range(0, 9) == 0) ? (NCH*TRIM_W)'($urandom) : trim,
                a_uv, b_uv);
            if ($urandom_range(0, 19) == 0) begin
                avdd.a = longint'($urandom_range(1000000, 2000000));
                avdd.b = longint'($urandom_range(0, 4000000)) - 64'sd2000000;
                avdd.t = 64'($time);
                async_check();
            end
            step_cycles(1);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
